tm1638_frame_sequencer: RTL
===========================

// Module: tm1638_frame_sequencer
// PURPOSE
//  Write-only sequencer for a TM1638 LED/7-seg board, driven from the 50 MHz system clock.
//  On each start request it latches eight digit segment patterns, eight LEDs and the display control.
//  It then emits one full refresh frame on tm_clk/tm_stb/tm_dio, as three transactions:
//  command 0x40, then address 0xC0 followed by 16 data bytes, then display control.
//  Sits between the counter/BCD datapath and the board pins; no key scan, tm_dio is output-only.
// PARAMETERS
//  CLK_DIV  25  system-clock cycles per serial half-bit (H); legal range >=1; 25 -> 1 MHz tm_clk
// PORTS
//  clk_50M     in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   frame request, sampled only in IDLE
//  seg_data    in   64  digit i segment pattern = seg_data[8*i+7:8*i], i=0..7 (digit 0 = leftmost grid)
//  led         in   8   led[i] drives LED i
//  brightness  in   3   pulse-width code 0..7
//  display_on  in   1   1 = display enabled
//  tm_clk      out  1   serial clock to TM1638, idles high
//  tm_stb      out  1   strobe, active low, idles high
//  tm_dio      out  1   serial data, LSB first, idles high
//  busy        out  1   high while a frame is in progress
//  done        out  1   one-cycle pulse at frame end
// BEHAVIOUR
//  Reset (async, immediate): tm_clk=1, tm_stb=1, tm_dio=1, busy=0, done=0, FSM=IDLE, counters=0.
//  Reset mid-frame aborts the frame with no completion; the next start sends a complete frame.
//  start=1 in IDLE at edge k: all inputs are latched at edge k. busy=1 from k+1.
//  Input changes after edge k do not affect the current frame. start while busy is ignored.
//  The byte stream is fixed:
//   T0: 0x40
//   T1: 0xC0, then for i=0..7: seg byte i, LED byte ({7'b0,led[i]})
//   T2: {4'b1000, display_on, brightness}
//  FSM: IDLE -> STB_SETUP -> SHIFT -> STB_HOLD -> GAP -> (next transaction STB_SETUP | FINISH) -> IDLE.
//   STB_SETUP: tm_stb=0, tm_clk=1 for H cycles.
//   SHIFT, per bit: tm_clk=0 for H cycles with tm_dio updated on the falling edge; then tm_clk=1 for H cycles.
//    The TM1638 samples tm_dio on the rising edge. Bits go LSB first; bytes of a transaction are sent back-to-back.
//   STB_HOLD: tm_clk=1 for H cycles, then tm_stb=1.
//   GAP: tm_stb=1 for 2H cycles. tm_dio returns to 1 when tm_stb rises.
//   FINISH: done=1 and busy=0 in the same single cycle, then IDLE.
//  Frame length: 19 bytes = 152 bits.
//   start edge k -> done cycle ends at edge k + (152*2 + 3*4)*H = k + 316*H.
//  Counters:
//   half-bit counter width = clog2(CLK_DIV)+1, wraps to 0 at CLK_DIV-1.
//   bit counter 0..7, wraps to 0 at 7.
//   byte index 0..16 within T1.
//   transaction index 0..2.
//  The start-sampling edge lies in IDLE, i.e. after FINISH. start held high through FINISH launches the next frame one cycle after done.
//  tm_stb never changes while tm_clk=0. tm_clk toggles only while tm_stb=0.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING (CLK_DIV=2 unless stated)
//  1. Hold rst_n=0 -> tm_clk=tm_stb=tm_dio=1, busy=done=0. Release -> outputs stay unchanged with start=0.
//  2. One-cycle start with seg_data=64'h3F06_5B4F_666D_7D07, led=8'h05, brightness=7, display_on=1:
//     - bus-model decode gives 0x40; 0xC0,07,01,7D,00,6D,01,66,00,4F,00,5B,00,06,00,3F,00; 0x8F
//     - done pulses at start+632 cycles.
//  3. Change seg_data and brightness one cycle after start -> decoded frame still matches the values latched at start.
//     Pulse start again mid-frame -> no extra frame.
//  4. Deassert rst_n during byte 5 of T1 -> all outputs idle immediately.
//     Restart -> one complete, correct 19-byte frame.
//  5. display_on=0, brightness=3 -> last byte 0x83.
//     Hold start high -> back-to-back frames; second frame's stb falls one cycle after done.
//  6. CLK_DIV=1 and CLK_DIV=25 -> tm_clk half-periods of 1 and 25 cycles; frame lengths 316 and 7900 cycles.

Source files
------------

// File: rtl/tm1638_frame_sequencer.sv
// Write-only TM1638 refresh sequencer: latches the display image on start and shifts out
// one frame (0x40 / 0xC0 + 16 data bytes / display control) on tm_clk, tm_stb and tm_dio.
module tm1638_frame_sequencer #(
  parameter int CLK_DIV = 25
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] seg_data,
  input  logic [7:0]  led,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  output logic        tm_clk,
  output logic        tm_stb,
  output logic        tm_dio,
  output logic        busy,
  output logic        done
);

  localparam int HW = $clog2(CLK_DIV) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_PEN  = HW'((CLK_DIV >= 2) ? CLK_DIV - 2 : 0);

  typedef enum logic [2:0] {
    IDLE, STB_SETUP, SHIFT, STB_HOLD, GAP, FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            half_q, half_d;
  logic [2:0]      bit_q, bit_d;
  logic [4:0]      byte_q, byte_d;
  logic [1:0]      txn_q, txn_d;
  logic            load;

  logic [63:0]     seg_q;
  logic [7:0]      led_q;
  logic [7:0]      ctrl_q;

  logic            tm_clk_q, tm_clk_d;
  logic            tm_stb_q, tm_stb_d;
  logic            tm_dio_q, tm_dio_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            hcnt_wrap;
  logic            gap_pen;
  logic [4:0]      last_byte;
  logic [7:0]      cur_byte;

  function automatic logic [7:0] frame_byte(input logic [1:0]  txn,
                                            input logic [4:0]  idx,
                                            input logic [63:0] seg,
                                            input logic [7:0]  leds,
                                            input logic [7:0]  ctrl);
    logic [4:0] j;
    logic [2:0] digit;
    j     = idx - 5'd1;
    digit = j[3:1];
    case (txn)
      2'd1: begin
        if (idx == 5'd0)   frame_byte = 8'hC0;
        else if (!j[0])    frame_byte = seg[{digit, 3'b000} +: 8];
        else               frame_byte = {7'b0, leds[digit]};
      end
      2'd2:    frame_byte = ctrl;
      default: frame_byte = 8'h40;
    endcase
  endfunction

  assign hcnt_wrap = (hcnt_q == H_LAST);
  assign last_byte = (txn_q == 2'd1) ? 5'd16 : 5'd0;
  // The final gap is one cycle short so that FINISH completes the 316*H frame budget.
  assign gap_pen   = (CLK_DIV == 1) ? !half_q : (half_q && (hcnt_q == H_PEN));

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    half_d  = half_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txn_d   = txn_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = STB_SETUP;
          hcnt_d  = '0;
          half_d  = 1'b0;
          bit_d   = '0;
          byte_d  = '0;
          txn_d   = '0;
        end
      end
      STB_SETUP: begin
        if (hcnt_wrap) begin
          hcnt_d  = '0;
          half_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          hcnt_d  = hcnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt_wrap) begin
          hcnt_d = '0;
          half_d = ~half_q;
          if (half_q) begin
            if (bit_q == 3'd7) begin
              bit_d = '0;
              if (byte_q == last_byte) begin
                byte_d  = '0;
                state_d = STB_HOLD;
              end else begin
                byte_d  = byte_q + 5'd1;
              end
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      STB_HOLD: begin
        if (hcnt_wrap) begin
          hcnt_d  = '0;
          half_d  = 1'b0;
          state_d = GAP;
        end else begin
          hcnt_d  = hcnt_q + 1'b1;
        end
      end
      GAP: begin
        if ((txn_q == 2'd2) && gap_pen) begin
          hcnt_d  = '0;
          half_d  = 1'b0;
          txn_d   = '0;
          state_d = FINISH;
        end else if (hcnt_wrap) begin
          hcnt_d = '0;
          if (half_q) begin
            half_d  = 1'b0;
            txn_d   = txn_q + 2'd1;
            state_d = STB_SETUP;
          end else begin
            half_d  = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so pins never glitch.
  always_comb begin
    cur_byte = frame_byte(txn_d, byte_d, seg_q, led_q, ctrl_q);
    tm_clk_d = 1'b1;
    tm_stb_d = 1'b1;
    tm_dio_d = 1'b1;
    busy_d   = (state_d != IDLE) && (state_d != FINISH);
    done_d   = (state_d == FINISH);
    case (state_d)
      STB_SETUP: tm_stb_d = 1'b0;
      SHIFT: begin
        tm_stb_d = 1'b0;
        tm_clk_d = half_d;
        tm_dio_d = cur_byte[bit_d];
      end
      STB_HOLD: begin
        tm_stb_d = 1'b0;
        tm_dio_d = tm_dio_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      half_q   <= 1'b0;
      bit_q    <= '0;
      byte_q   <= '0;
      txn_q    <= '0;
      tm_clk_q <= 1'b1;
      tm_stb_q <= 1'b1;
      tm_dio_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      txn_q    <= txn_d;
      tm_clk_q <= tm_clk_d;
      tm_stb_q <= tm_stb_d;
      tm_dio_q <= tm_dio_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the display image is pure datapath, always loaded before use, so it carries no reset.
  always_ff @(posedge clk_50M) begin
    if (load) begin
      seg_q  <= seg_data;
      led_q  <= led;
      ctrl_q <= {4'b1000, display_on, brightness};
    end
  end

  assign tm_clk = tm_clk_q;
  assign tm_stb = tm_stb_q;
  assign tm_dio = tm_dio_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
